// File: rtl/pwm_duty_decoder.sv
// PWM receive-side decoder: synchronizes a PWM line, measures period and high time between
// rising edges, and recovers the speed word with lock and period-error indications.
module pwm_duty_decoder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned TOL        = 2,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             enable,
  input  logic             pwm_data,
  output logic [WIDTH-1:0] speed,
  output logic             speed_valid,
  output logic             locked,
  output logic             period_err
);

  localparam int unsigned Period = 2 ** WIDTH;
  localparam int unsigned PerW   = WIDTH + 2;
  localparam int unsigned HiW    = WIDTH + 1;
  localparam int unsigned GoodW  = $clog2(LOCK_COUNT + 1);

  localparam logic [PerW-1:0]  PerNominal = PerW'(Period);
  localparam logic [PerW-1:0]  PerMin     = PerW'(Period - TOL);
  localparam logic [PerW-1:0]  PerMax     = PerW'(Period + TOL);
  // Timeout fires on the edge at which the count would reach 2*PERIOD.
  localparam logic [PerW-1:0]  PerLast    = PerW'(2 * Period - 1);
  localparam logic [HiW-1:0]   HiMax      = HiW'(Period - 1);
  localparam logic [GoodW-1:0] GoodLock   = GoodW'(LOCK_COUNT);

  typedef enum logic [1:0] {StIdle, StSeek, StMeasure} state_e;

  state_e state_q, state_d;

  logic s1_q, s2_q, s3_q;
  logic [PerW-1:0]  per_cnt_q, per_cnt_d;
  logic [HiW-1:0]   hi_cnt_q, hi_cnt_d;
  logic [GoodW-1:0] good_cnt_q, good_cnt_d;
  logic [WIDTH-1:0] speed_q, speed_d;
  logic             speed_valid_q, speed_valid_d;
  logic             locked_q, locked_d;
  logic             period_err_q, period_err_d;

  logic             rise;
  logic             timeout;
  logic             period_ok;
  logic             active;
  logic [GoodW-1:0] good_inc;

  assign rise      = s2_q & ~s3_q;
  assign timeout   = (per_cnt_q == PerLast);
  assign period_ok = (per_cnt_q >= PerMin) && (per_cnt_q <= PerMax);
  assign active    = enable && (state_q != StIdle);
  assign good_inc  = (good_cnt_q >= GoodLock) ? GoodLock : good_cnt_q + GoodW'(1);

  // State register and all datapath flops.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= StIdle;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      per_cnt_q     <= '0;
      hi_cnt_q      <= '0;
      good_cnt_q    <= '0;
      speed_q       <= '0;
      speed_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      period_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      s1_q          <= pwm_data;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      per_cnt_q     <= per_cnt_d;
      hi_cnt_q      <= hi_cnt_d;
      good_cnt_q    <= good_cnt_d;
      speed_q       <= speed_d;
      speed_valid_q <= speed_valid_d;
      locked_q      <= locked_d;
      period_err_q  <= period_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StSeek;
        StSeek:    if (rise) state_d = StMeasure;
        // A constant-level verdict re-seeks so the next rise opens a fresh period.
        StMeasure: if (!rise && timeout) state_d = StSeek;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Counters and registered outputs.
  always_comb begin
    per_cnt_d     = (&per_cnt_q) ? per_cnt_q : per_cnt_q + PerW'(1);
    hi_cnt_d      = (s2_q && !(&hi_cnt_q)) ? hi_cnt_q + HiW'(1) : hi_cnt_q;
    good_cnt_d    = good_cnt_q;
    speed_d       = speed_q;
    speed_valid_d = 1'b0;
    locked_d      = locked_q;
    period_err_d  = 1'b0;

    if (!active) begin
      per_cnt_d  = '0;
      hi_cnt_d   = '0;
      good_cnt_d = '0;
      locked_d   = 1'b0;
    end else if (rise) begin
      per_cnt_d = PerW'(1);
      hi_cnt_d  = HiW'(1);
      if (state_q == StMeasure) begin
        if (period_ok) begin
          speed_d       = (hi_cnt_q > HiMax) ? '1 : hi_cnt_q[WIDTH-1:0];
          speed_valid_d = 1'b1;
          good_cnt_d    = good_inc;
          locked_d      = (good_inc == GoodLock);
        end else begin
          period_err_d = 1'b1;
          good_cnt_d   = '0;
          locked_d     = 1'b0;
        end
      end
    end else if (timeout) begin
      speed_d       = s2_q ? '1 : '0;
      speed_valid_d = 1'b1;
      locked_d      = 1'b1;
      good_cnt_d    = '0;
      per_cnt_d     = PerNominal;
    end
  end

  assign speed       = speed_q;
  assign speed_valid = speed_valid_q;
  assign locked      = locked_q;
  assign period_err  = period_err_q;

endmodule
